display_frame_ctrl: RTL and testbench

Frame-transfer sequencer for the display adapter capture path. On a start pulse it reads NUM_PIXELS packed 32-bit pixel words ({8'h00, R, G, B}) from a frame memory with 1-cycle read latency. Each word is serialised as three bytes in R, G, B order onto frame_out, qualified by cs_display. A byte moves only on a cycle where cs_display and sink_ready are both high. The block drives the byte-capture side of the adapter, which rebuilds pixels from that R/G/B sequence.

---
 rtl/display_pkg.sv | 34 +++
 rtl/pixel_serializer.sv | 44 ++++
 rtl/display_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_display_frame_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared state encoding, byte-lane constants and lane selection for the display frame sequencer.
// The BLANK state exists only when LINE_BLANK_EN is defined.
package display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND_R,
    SEND_G,
    SEND_B,
    DONE
`ifdef LINE_BLANK_EN
    ,
    BLANK
`endif
  } state_t;

  localparam int R_MSB     = 23;
  localparam int G_MSB     = 15;
  localparam int B_MSB     = 7;
  localparam int PIX_BYTES = 3;

  // Byte lane 0/1/2 maps to R/G/B of a packed 24-bit pixel.
  function automatic logic [7:0] lane_byte(input logic [23:0] pixel, input logic [1:0] idx);
    case (idx)
      2'd0:    return pixel[R_MSB -: 8];
      2'd1:    return pixel[G_MSB -: 8];
      2'd2:    return pixel[B_MSB -: 8];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pixel_serializer.sv
// Holds one fetched pixel and presents its R, G, B bytes on a registered output.
// The byte index only moves on advance, so a stalled sink sees a stable byte.
module pixel_serializer
  import display_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        advance,
  input  logic [23:0] rdata,
  output logic [7:0]  frame_out,
  output logic        last_byte
);

  logic [23:0] pixel;
  logic [1:0]  byte_idx;
  logic [1:0]  next_idx;

  assign next_idx  = byte_idx + 2'd1;
  assign last_byte = (byte_idx == 2'(PIX_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pixel     <= '0;
      byte_idx  <= '0;
      frame_out <= '0;
    end else if (load) begin
      pixel     <= rdata;
      byte_idx  <= '0;
      frame_out <= lane_byte(rdata, 2'd0);
    end else if (advance) begin
      // Once B has gone out the lane is idle until the next load.
      if (last_byte) begin
        byte_idx  <= '0;
        frame_out <= '0;
      end else begin
        byte_idx  <= next_idx;
        frame_out <= lane_byte(pixel, next_idx);
      end
    end
  end

endmodule

// File: rtl/display_frame_ctrl.sv
// Frame-transfer sequencer: fetches NUM_PIXELS words and streams each as R, G, B bytes.
// Define LINE_BLANK_EN to insert a one-cycle BLANK gap after every LINE_PIXELS pixels.
module display_frame_ctrl
  import display_pkg::*;
#(
  parameter int NUM_PIXELS  = 200,
  parameter int ADDR_W      = 8,
  parameter int LINE_PIXELS = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sink_ready,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [31:0]       pix_rdata,
  output logic [7:0]        frame_out,
  output logic              cs_display,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(NUM_PIXELS - 1);

  state_t            state, state_d;
  logic [ADDR_W:0]   cnt, cnt_d;
  logic [ADDR_W-1:0] pix_addr_d;
  logic              pix_rd_en_d, cs_d, busy_d, done_d;
  logic              load, advance, clear, last_byte;
  logic              unused_rdata;

  assign unused_rdata = ^pix_rdata[31:24];

`ifdef LINE_BLANK_EN
  localparam logic [ADDR_W:0] LINE_LAST = (ADDR_W + 1)'(LINE_PIXELS - 1);
  logic [ADDR_W:0] line_cnt, line_cnt_d;
`else
  logic unused_line;
  assign unused_line = (LINE_PIXELS == 0);
`endif

  pixel_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .advance   (advance),
    .rdata     (pix_rdata[23:0]),
    .frame_out (frame_out),
    .last_byte (last_byte)
  );

  // Outputs are computed one cycle ahead and registered together with the state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pix_addr_d  = pix_addr;
    pix_rd_en_d = 1'b0;
    cs_d        = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    clear       = 1'b0;
`ifdef LINE_BLANK_EN
    line_cnt_d  = line_cnt;
`endif
    if (abort && state != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      clear   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state_d     = FETCH;
            cnt_d       = '0;
            pix_addr_d  = '0;
            pix_rd_en_d = 1'b1;
            busy_d      = 1'b1;
`ifdef LINE_BLANK_EN
            line_cnt_d  = '0;
`endif
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          state_d = SEND_R;
          load    = 1'b1;
          cs_d    = 1'b1;
        end
        SEND_R: begin
          cs_d    = 1'b1;
          advance = sink_ready;
          if (sink_ready) state_d = SEND_G;
        end
        SEND_G: begin
          cs_d    = 1'b1;
          advance = sink_ready;
          if (sink_ready) state_d = SEND_B;
        end
        SEND_B: begin
          cs_d    = 1'b1;
          advance = sink_ready;
          if (sink_ready && last_byte) begin
            cs_d = 1'b0;
            if (cnt == LAST_PIX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d       = cnt + 1'b1;
              pix_addr_d  = cnt_d[ADDR_W-1:0];
              state_d     = FETCH;
              pix_rd_en_d = 1'b1;
`ifdef LINE_BLANK_EN
              // Line boundary: hold off the next fetch for one gap cycle.
              if (line_cnt == LINE_LAST) begin
                line_cnt_d  = '0;
                state_d     = BLANK;
                pix_rd_en_d = 1'b0;
              end else begin
                line_cnt_d = line_cnt + 1'b1;
              end
`endif
            end
          end
        end
`ifdef LINE_BLANK_EN
        BLANK: begin
          state_d     = FETCH;
          pix_addr_d  = cnt[ADDR_W-1:0];
          pix_rd_en_d = 1'b1;
        end
`endif
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pix_addr   <= '0;
      pix_rd_en  <= 1'b0;
      cs_display <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef LINE_BLANK_EN
      line_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pix_addr   <= pix_addr_d;
      pix_rd_en  <= pix_rd_en_d;
      cs_display <= cs_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef LINE_BLANK_EN
      line_cnt   <= line_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_display_frame_ctrl.sv
// Scoreboard bench for display_frame_ctrl: expected bytes are queued at start and popped on each transfer.
// Builds with LINE_BLANK_EN for the 6-pixel / 2-per-line blanking configuration.
`timescale 1ns/1ps
module tb_display_frame_ctrl;

  localparam int AW = 8;
`ifdef LINE_BLANK_EN
  localparam int NP = 6;
  localparam int LP = 2;
`else
  localparam int NP = 4;
  localparam int LP = 20;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sink_ready = 1'b1;
  logic          pix_rd_en, cs_display, busy, done;
  logic [AW-1:0] pix_addr;
  logic [31:0]   pix_rdata = '0;
  logic [7:0]    frame_out;

  logic [31:0] mem [0:255];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  int          n_cmp = 0;
  int          n_fail = 0;

  display_frame_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW), .LINE_PIXELS(LP)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .sink_ready (sink_ready),
    .pix_rd_en  (pix_rd_en),
    .pix_addr   (pix_addr),
    .pix_rdata  (pix_rdata),
    .frame_out  (frame_out),
    .cs_display (cs_display),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Frame memory with one cycle of read latency.
  always @(posedge clock) begin
    if (pix_rd_en) pix_rdata <= mem[pix_addr];
  end

  // Every accepted byte must be the next one the bench queued.
  always @(negedge clock) begin
    if (!reset && !abort && cs_display && sink_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL byte_extra: got %02h, wanted no byte (queue empty)", frame_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (frame_out !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL byte_value: got %02h, wanted %02h", frame_out, mon_exp);
        end
      end
    end
  end

  function automatic int blanks_before(input int i);
`ifdef LINE_BLANK_EN
    return i / LP;
`else
    return 0 * i;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      exp_q.push_back(mem[i][23:16]);
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
  endtask

  task automatic launch();
    tick();
    start = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({pix_rd_en, pix_addr, frame_out, cs_display, busy, done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h, wanted 0",
               {pix_rd_en, pix_addr, frame_out, cs_display, busy, done});
    end
  endtask

  task automatic test_main_frame();
    int first_cs = -1, done_cyc = -1, done_cnt = 0, nbytes = 0, exp_k;
    mem[0] = 32'h00112233;
    mem[1] = 32'h00445566;
    mem[2] = 32'h00778899;
    mem[3] = 32'h00AABBCC;
    for (int i = 4; i < NP; i++) mem[i] = {8'h00, 24'($urandom)};
    sink_ready = 1'b1;
    push_frame(NP);
    launch();
    for (int k = 1; k <= 5 * NP + 20; k++) begin
      tick();
      start = 1'b0;
      @(negedge clock);
      if (k == 1) begin
        n_cmp++;
        if ({busy, pix_rd_en, pix_addr} !== {2'b11, 8'h00}) begin
          n_fail++;
          $display("[TB] FAIL first_fetch: got busy/rd/addr %h, wanted 300", {busy, pix_rd_en, pix_addr});
        end
      end
      if (cs_display && first_cs < 0) first_cs = k;
      if (cs_display && sink_ready) begin
        if (nbytes % 3 == 0) begin
          exp_k = 3 + 5 * (nbytes / 3) + blanks_before(nbytes / 3);
          n_cmp++;
          if (k !== exp_k) begin
            n_fail++;
            $display("[TB] FAIL pixel_start: pixel %0d got cycle %0d, wanted %0d", nbytes / 3, k, exp_k);
          end
        end
        nbytes++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    n_cmp++;
    if (first_cs !== 3) begin
      n_fail++;
      $display("[TB] FAIL first_byte_latency: got cycle %0d, wanted 3", first_cs);
    end
    n_cmp++;
    if (done_cyc !== 5 * NP + 1 + blanks_before(NP - 1) || done_cnt !== 1) begin
      n_fail++;
      $display("[TB] FAIL done_timing: got cycle %0d count %0d, wanted cycle %0d count 1",
               done_cyc, done_cnt, 5 * NP + 1 + blanks_before(NP - 1));
    end
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() !== 0 || nbytes !== 3 * NP) begin
      n_fail++;
      $display("[TB] FAIL frame_end: got busy %b left %0d bytes %0d, wanted 0 0 %0d",
               busy, exp_q.size(), nbytes, 3 * NP);
    end
  endtask

  task automatic test_top_byte();
    logic [7:0] want [3] = '{8'h0A, 8'h0B, 8'h0C};
    bit done_seen = 0;
    mem[0] = 32'hFF0A0B0C;
    for (int i = 1; i < NP; i++) mem[i] = $urandom;
    push_frame(NP);
    launch();
    for (int k = 1; k <= 5 * NP + 20; k++) begin
      tick();
      start = 1'b0;
      @(negedge clock);
      if (k >= 3 && k <= 5) begin
        n_cmp++;
        if (frame_out !== want[k - 3]) begin
          n_fail++;
          $display("[TB] FAIL top_byte_drop: cycle %0d got %02h, wanted %02h", k, frame_out, want[k - 3]);
        end
      end
      if (done) done_seen = 1;
    end
    n_cmp++;
    if (!done_seen || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL top_byte_frame: got done %0d left %0d, wanted 1 0", done_seen, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int done_cyc = -1;
    for (int i = 0; i < NP; i++) mem[i] = {8'h00, 24'($urandom)};
    push_frame(NP);
    launch();
    for (int k = 1; k <= 5 * NP + 25; k++) begin
      tick();
      start = 1'b0;
      sink_ready = !(k >= 9 && k <= 11);
      @(negedge clock);
      if (k >= 9 && k <= 12) begin
        n_cmp++;
        if (frame_out !== mem[1][15:8] || cs_display !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: cycle %0d got %02h cs %b, wanted %02h cs 1",
                   k, frame_out, cs_display, mem[1][15:8]);
        end
      end
      if (done && done_cyc < 0) done_cyc = k;
    end
    sink_ready = 1'b1;
    n_cmp++;
    if (done_cyc !== 5 * NP + 4 + blanks_before(NP - 1) || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL stall_length: got done %0d left %0d, wanted done %0d left 0",
               done_cyc, exp_q.size(), 5 * NP + 4 + blanks_before(NP - 1));
    end
  endtask

  task automatic test_abort();
    int  ab_k = 5 + 10 + blanks_before(2);
    int  done_cyc = -1;
    bit  idle_bad = 0;
    bit  done_seen = 0;
    for (int i = 0; i < NP; i++) mem[i] = {8'h00, 24'($urandom)};
    push_frame(2);
    exp_q.push_back(mem[2][23:16]);
    exp_q.push_back(mem[2][15:8]);
    launch();
    for (int k = 1; k <= ab_k + 8; k++) begin
      tick();
      start = 1'b0;
      abort = (k == ab_k);
      @(negedge clock);
      if (done) done_seen = 1;
      if (k == ab_k + 1) begin
        n_cmp++;
        if ({cs_display, busy, done, pix_rd_en} !== 4'b0000) begin
          n_fail++;
          $display("[TB] FAIL abort_next: got cs/busy/done/rd %b, wanted 0000",
                   {cs_display, busy, done, pix_rd_en});
        end
      end
    end
    n_cmp++;
    if (done_seen || busy !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: got done %0d busy %b left %0d, wanted 0 0 0",
               done_seen, busy, exp_q.size());
    end
    // Abort together with start while idle must not begin a frame.
    tick();
    start = 1'b1;
    abort = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clock);
      if (busy !== 1'b0 || pix_rd_en !== 1'b0) idle_bad = 1;
    end
    n_cmp++;
    if (idle_bad) begin
      n_fail++;
      $display("[TB] FAIL abort_start_idle: got a frame start, wanted none");
    end
    push_frame(NP);
    launch();
    for (int k = 1; k <= 5 * NP + 20; k++) begin
      tick();
      start = 1'b0;
      @(negedge clock);
      if (k == 1) begin
        n_cmp++;
        if (pix_rd_en !== 1'b1 || pix_addr !== '0) begin
          n_fail++;
          $display("[TB] FAIL replay_addr: got rd %b addr %0d, wanted rd 1 addr 0", pix_rd_en, pix_addr);
        end
      end
      if (done && done_cyc < 0) done_cyc = k;
    end
    n_cmp++;
    if (done_cyc !== 5 * NP + 1 + blanks_before(NP - 1) || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL replay_frame: got done %0d left %0d, wanted done %0d left 0",
               done_cyc, exp_q.size(), 5 * NP + 1 + blanks_before(NP - 1));
    end
  endtask

  task automatic test_start_busy();
    int dc = 5 * NP + 1 + blanks_before(NP - 1);
    int done_cyc = -1, done_cnt = 0;
    bit late_busy = 0;
    for (int i = 0; i < NP; i++) mem[i] = {8'h00, 24'($urandom)};
    push_frame(NP);
    launch();
    for (int k = 1; k <= dc + 12; k++) begin
      tick();
      start = (k == 4 || k == 10 || k == dc);
      @(negedge clock);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k > dc && busy) late_busy = 1;
    end
    start = 1'b0;
    n_cmp++;
    if (done_cyc !== dc || done_cnt !== 1 || late_busy || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL start_while_busy: got done %0d x%0d late_busy %0d left %0d, wanted %0d x1 0 0",
               done_cyc, done_cnt, late_busy, exp_q.size(), dc);
    end
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    for (int i = 0; i < NP; i++) mem[i] = {8'h00, 24'($urandom)};
    push_frame(2);
    launch();
    for (int k = 1; k <= 30; k++) begin
      tick();
      start = 1'b0;
      reset = (k == 12);
      @(negedge clock);
      if (k == 13) begin
        n_cmp++;
        if ({pix_rd_en, pix_addr, frame_out, cs_display, busy, done} !== '0) begin
          n_fail++;
          $display("[TB] FAIL reset_mid_outputs: got %h, wanted 0",
                   {pix_rd_en, pix_addr, frame_out, cs_display, busy, done});
        end
      end
      if (k > 13 && (busy || cs_display || done || pix_rd_en)) stray = 1;
    end
    n_cmp++;
    if (stray || exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_idle: got activity %0d left %0d, wanted 0 0", stray, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    $display("[TB] display_frame_ctrl bench, NUM_PIXELS=%0d", NP);
    test_reset();
    test_main_frame();
    test_top_byte();
    test_stall();
    test_abort();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
